spi_flash_rd_arbiter: RTL and testbench

//  Shares one quad-SPI flash read engine between two AXI4-Lite read-only masters:
//  M0 = instruction fetch, M1 = data loads.

---
 rtl/spi_flash_rd_arbiter_if.sv | 46 ++++
 rtl/spi_flash_rd_arbiter.sv | 128 ++++++++++++
 tb/tb_spi_flash_rd_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_rd_arbiter_if.sv
// Signal bundle between the two AXI4-Lite read masters, the flash read arbiter and the SPI read engine.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface spi_flash_rd_arbiter_if #(
  parameter int ADDR_SIZE = 24,
  parameter int DATA_SIZE = 32
);
  logic                 m0_arvalid;
  logic                 m0_arready;
  logic [ADDR_SIZE-1:0] m0_araddr;
  logic                 m0_rvalid;
  logic                 m0_rready;
  logic [DATA_SIZE-1:0] m0_rdata;
  logic [1:0]           m0_rresp;

  logic                 m1_arvalid;
  logic                 m1_arready;
  logic [ADDR_SIZE-1:0] m1_araddr;
  logic                 m1_rvalid;
  logic                 m1_rready;
  logic [DATA_SIZE-1:0] m1_rdata;
  logic [1:0]           m1_rresp;

  logic                 eng_start;
  logic [ADDR_SIZE-1:0] eng_addr;
  logic                 eng_abort;
  logic                 eng_done;
  logic [DATA_SIZE-1:0] eng_rdata;

  modport slave (
    input  m0_arvalid, m0_araddr, m0_rready,
    output m0_arready, m0_rvalid, m0_rdata, m0_rresp,
    input  m1_arvalid, m1_araddr, m1_rready,
    output m1_arready, m1_rvalid, m1_rdata, m1_rresp,
    output eng_start, eng_addr, eng_abort,
    input  eng_done, eng_rdata
  );

  modport master (
    output m0_arvalid, m0_araddr, m0_rready,
    input  m0_arready, m0_rvalid, m0_rdata, m0_rresp,
    output m1_arvalid, m1_araddr, m1_rready,
    input  m1_arready, m1_rvalid, m1_rdata, m1_rresp,
    input  eng_start, eng_addr, eng_abort,
    output eng_done, eng_rdata
  );
endinterface

// File: rtl/spi_flash_rd_arbiter.sv
// Round-robin arbiter sharing one quad-SPI flash read engine between an instruction-fetch
// and a data-load AXI4-Lite read master, with a watchdog that converts a hung engine into SLVERR.
module spi_flash_rd_arbiter #(
  parameter int ADDR_SIZE = 24,
  parameter int DATA_SIZE = 32,
  parameter int TIMEOUT   = 1024
) (
  input logic                 ACLK,
  input logic                 ARESET,
  spi_flash_rd_arbiter_if.slave bus
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 grant_q;
  logic                 last_grant_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_SIZE-1:0] rdata_q;
  logic [1:0]           rresp_q;

  logic                 sel1;
  logic                 req_any;
  logic                 ar_hs;
  logic                 r_hs;
  logic                 start;
  logic                 abort;
  logic                 cap_ok;

  // Arbitration: a lone requester wins outright; a tie goes to the master not served last.
  always_comb begin
    req_any = bus.m0_arvalid || bus.m1_arvalid;
    sel1    = bus.m1_arvalid && (!bus.m0_arvalid || !last_grant_q);
    ar_hs   = (state_q == IDLE) && !ARESET && req_any;
    r_hs    = (state_q == RESP) && (grant_q ? bus.m1_rready : bus.m0_rready);
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    cap_ok  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ar_hs) state_d = ISSUE;
      end
      ISSUE: begin
        start   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the watchdog's last cycle still counts as a good read.
        if (bus.eng_done) begin
          cap_ok  = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (r_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        grant_q <= sel1;
        addr_q  <= sel1 ? bus.m1_araddr : bus.m0_araddr;
      end
      if (start)                 cnt_q <= '0;
      else if (state_q == WAIT)  cnt_q <= cnt_q + CNT_W'(1);
      if (cap_ok) begin
        rdata_q <= bus.eng_rdata;
        rresp_q <= RESP_OKAY;
      end else if (abort) begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end
      if (r_hs) last_grant_q <= grant_q;
    end
  end

  // Output drive: only the granted master ever sees rvalid; arready is forced low while in reset.
  assign bus.m0_arready = ar_hs && !sel1;
  assign bus.m1_arready = ar_hs &&  sel1;
  assign bus.m0_rvalid  = (state_q == RESP) && !grant_q;
  assign bus.m1_rvalid  = (state_q == RESP) &&  grant_q;
  assign bus.m0_rdata   = rdata_q;
  assign bus.m1_rdata   = rdata_q;
  assign bus.m0_rresp   = rresp_q;
  assign bus.m1_rresp   = rresp_q;
  assign bus.eng_start  = start;
  assign bus.eng_addr   = addr_q;
  assign bus.eng_abort  = abort;

  a_one_arready: assert property (@(posedge ACLK) disable iff (ARESET)
    !(bus.m0_arready && bus.m1_arready));
  a_start_abort_excl: assert property (@(posedge ACLK) disable iff (ARESET)
    !(bus.eng_start && bus.eng_abort));

endmodule

// File: tb/tb_spi_flash_rd_arbiter.sv
// Directed bench for the flash read arbiter: table of transactions plus hand-written corner sequences.
module tb_spi_flash_rd_arbiter;
  localparam int TO = 16;

  logic ACLK;
  logic ARESET;
  int   n_tests = 0;
  int   n_fail  = 0;

  spi_flash_rd_arbiter_if #(.ADDR_SIZE(24), .DATA_SIZE(32)) bus ();

  spi_flash_rd_arbiter #(.ADDR_SIZE(24), .DATA_SIZE(32), .TIMEOUT(TO)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          rst;
    bit          req0;
    bit          req1;
    logic [23:0] a0;
    logic [23:0] a1;
    int          dly;      // cycles from eng_start to eng_done, 0 = never
    logic [31:0] data;
    int          hold;     // cycles rready is held low in RESP
    bit          pend0;    // raise an M0 request during the hold
    bit          exp_grant;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
    bit          exp_abort;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m0_arvalid = 1'b0; bus.m0_araddr = '0; bus.m0_rready = 1'b0;
    bus.m1_arvalid = 1'b0; bus.m1_araddr = '0; bus.m1_rready = 1'b0;
    bus.eng_done   = 1'b0; bus.eng_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ARESET = 1'b1;
    tick();
    tick();
    ARESET = 1'b0;
    tick();
  endtask

  task automatic run_txn(input vec_t v);
    int          n, k, abort_cnt, abort_k, rv_k;
    logic [31:0] held;
    bus.m0_arvalid = v.req0; bus.m0_araddr = v.a0;
    bus.m1_arvalid = v.req1; bus.m1_araddr = v.a1;
    bus.eng_rdata  = v.data;
    bus.m0_rready  = 1'b0;   bus.m1_rready  = 1'b0;
    #1;
    n = 0;
    while (!(bus.m0_arready || bus.m1_arready) && n < 8) begin
      tick();
      n++;
    end
    chk("ar_handshake", bus.m0_arready | bus.m1_arready, 1);
    chk("grant_m1", bus.m1_arready, v.exp_grant);
    chk("grant_m0", bus.m0_arready, !v.exp_grant);
    tick();
    if (v.exp_grant) bus.m1_arvalid = 1'b0; else bus.m0_arvalid = 1'b0;
    chk("eng_start", bus.eng_start, 1);
    chk("eng_addr", bus.eng_addr, v.exp_grant ? v.a1 : v.a0);
    k = 0; abort_cnt = 0; abort_k = 0; rv_k = 0;
    while (rv_k == 0 && k < TO + 4) begin
      tick();
      k++;
      bus.eng_done = (k == v.dly);
      #1;
      if (bus.eng_abort) begin abort_cnt++; abort_k = k; end
      if (v.exp_grant ? bus.m1_rvalid : bus.m0_rvalid) rv_k = k;
    end
    bus.eng_done = 1'b0;
    chk("r_latency", rv_k, v.exp_abort ? TO + 1 : v.dly + 1);
    chk("abort_cnt", abort_cnt, v.exp_abort);
    if (v.exp_abort) chk("abort_at", abort_k, TO);
    chk("other_rvalid", v.exp_grant ? bus.m0_rvalid : bus.m1_rvalid, 0);
    chk("rdata", v.exp_grant ? bus.m1_rdata : bus.m0_rdata, v.exp_rdata);
    chk("rresp", v.exp_grant ? bus.m1_rresp : bus.m0_rresp, v.exp_rresp);
    held = v.exp_grant ? bus.m1_rdata : bus.m0_rdata;
    for (int h = 0; h < v.hold; h++) begin
      if (h == 0 && v.pend0) begin
        bus.m0_arvalid = 1'b1;
        bus.m0_araddr  = 24'h000040;
      end
      tick();
      chk("hold_rvalid", v.exp_grant ? bus.m1_rvalid : bus.m0_rvalid, 1);
      chk("hold_rdata", v.exp_grant ? bus.m1_rdata : bus.m0_rdata, held);
      chk("hold_arready", bus.m0_arready | bus.m1_arready, 0);
    end
    if (v.exp_grant) bus.m1_rready = 1'b1; else bus.m0_rready = 1'b1;
    tick();
    bus.m0_rready = 1'b0;
    bus.m1_rready = 1'b0;
    #1;
    chk("rvalid_drop", bus.m0_rvalid | bus.m1_rvalid, 0);
    if (v.pend0) chk("pend_arready", bus.m0_arready, 1);
  endtask

  initial begin
    vec_t sp;
    //          rst req0 req1 a0          a1          dly data          hold pend grant rdata         rresp  abort
    vecs[0] = '{1, 1, 0, 24'h000100, 24'h000000, 5,  32'hDEADBEEF, 0,  0,   0, 32'hDEADBEEF, 2'b00, 0};
    vecs[1] = '{1, 1, 1, 24'h001000, 24'h002004, 3,  32'h11111111, 0,  0,   0, 32'h11111111, 2'b00, 0};
    vecs[2] = '{0, 1, 1, 24'h001000, 24'h002004, 1,  32'h22222222, 0,  0,   1, 32'h22222222, 2'b00, 0};
    vecs[3] = '{0, 1, 1, 24'h001000, 24'h002004, 2,  32'h33333333, 0,  0,   0, 32'h33333333, 2'b00, 0};
    vecs[4] = '{0, 0, 1, 24'h000000, 24'h000003, 0,  32'hA5A5A5A5, 0,  0,   1, 32'h00000000, 2'b10, 1};
    vecs[5] = '{0, 1, 0, 24'hFFFFFC, 24'h000000, 16, 32'hCAFEF00D, 0,  0,   0, 32'hCAFEF00D, 2'b00, 0};
    vecs[6] = '{0, 0, 1, 24'h000000, 24'h7FFFFF, 15, 32'h12345678, 0,  0,   1, 32'h12345678, 2'b00, 0};
    vecs[7] = '{0, 0, 1, 24'h000000, 24'h00ABCD, 2,  32'h0BADCAFE, 10, 1,   1, 32'h0BADCAFE, 2'b00, 0};
    vecs[8] = '{0, 1, 0, 24'h000040, 24'h000000, 4,  32'hFEEDFACE, 0,  0,   0, 32'hFEEDFACE, 2'b00, 0};

    clear_inputs();
    ARESET = 1'b1;
    bus.m0_arvalid = 1'b1;
    tick();
    chk("rst_m0_arready", bus.m0_arready, 0);
    chk("rst_m1_arready", bus.m1_arready, 0);
    chk("rst_m0_rvalid", bus.m0_rvalid, 0);
    chk("rst_m1_rvalid", bus.m1_rvalid, 0);
    chk("rst_rdata", bus.m0_rdata | bus.m1_rdata, 0);
    chk("rst_rresp", bus.m0_rresp | bus.m1_rresp, 0);
    chk("rst_eng_start", bus.eng_start, 0);
    chk("rst_eng_addr", bus.eng_addr, 0);
    chk("rst_eng_abort", bus.eng_abort, 0);
    bus.m0_arvalid = 1'b0;
    ARESET = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      run_txn(vecs[i]);
    end

    // Spurious done while idle must not produce a response.
    clear_inputs();
    tick();
    bus.eng_done  = 1'b1;
    bus.eng_rdata = 32'h99999999;
    tick();
    bus.eng_done = 1'b0;
    chk("spur_rvalid_now", bus.m0_rvalid | bus.m1_rvalid, 0);
    tick();
    chk("spur_rvalid", bus.m0_rvalid | bus.m1_rvalid, 0);
    chk("spur_start", bus.eng_start, 0);
    sp = '{0, 1, 0, 24'h000200, 24'h000000, 3, 32'h5A5A0001, 0, 0, 0, 32'h5A5A0001, 2'b00, 0};
    run_txn(sp);

    // Reset while waiting on the engine.
    clear_inputs();
    bus.m1_arvalid = 1'b1;
    bus.m1_araddr  = 24'h0000AA;
    #1;
    chk("mid_arready", bus.m1_arready, 1);
    tick();
    bus.m1_arvalid = 1'b0;
    chk("mid_start", bus.eng_start, 1);
    tick();
    tick();
    chk("mid_addr", bus.eng_addr, 24'h0000AA);
    ARESET = 1'b1;
    #1;
    chk("mid_rst_addr", bus.eng_addr, 0);
    chk("mid_rst_start", bus.eng_start, 0);
    chk("mid_rst_abort", bus.eng_abort, 0);
    chk("mid_rst_rvalid", bus.m0_rvalid | bus.m1_rvalid, 0);
    chk("mid_rst_rdata", bus.m1_rdata, 0);
    tick();
    ARESET = 1'b0;
    tick();
    chk("mid_post_abort", bus.eng_abort, 0);
    sp = '{0, 0, 1, 24'h000000, 24'h123456, 4, 32'h600DF00D, 0, 0, 1, 32'h600DF00D, 2'b00, 0};
    run_txn(sp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
